gray_to_bin_serial: RTL and testbench

Sequential Gray-to-binary decoder, the receive-side counterpart of the team's binary-to-Gray encoder. It accepts one Gray-coded word per valid/ready handshake and decodes it MSB-first, one bit per clock. It presents the binary result on a second valid/ready interface. It also flags any decoded value that is not exactly the previous accepted value +1 (mod 2^WIDTH), which makes it usable as a monitor on a Gray counter stream.

---
 rtl/gray_to_bin_serial_pkg.sv | 13 +
 rtl/gray_to_bin_serial_if.sv | 26 ++
 rtl/gray_to_bin_serial_step_check.sv | 38 +++
 rtl/gray_to_bin_serial.sv | 100 ++++++++++
 tb/tb_gray_to_bin_serial.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/gray_to_bin_serial_pkg.sv
// Shared types and default widths for the Gray encode/decode blocks.
package gray_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DECODE,
        HOLD
    } state_t;

    localparam int GRAY_W     = 4;
    localparam int GRAY_ERR_W = 8;

endpackage

// File: rtl/gray_to_bin_serial_if.sv
// Input and result handshakes of the serial Gray-to-binary decoder.
interface gray_to_bin_serial_if
    import gray_pkg::*;
#(
    parameter int WIDTH = GRAY_W,
    parameter int ERR_W = GRAY_ERR_W
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_gray;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_bin;
    logic             out_step_err;
    logic [ERR_W-1:0] err_count;

    modport master (
        output in_valid, in_gray, out_ready,
        input  in_ready, out_valid, out_bin, out_step_err, err_count
    );

    modport slave (
        input  in_valid, in_gray, out_ready,
        output in_ready, out_valid, out_bin, out_step_err, err_count
    );
endinterface

// File: rtl/gray_to_bin_serial_step_check.sv
// Tracks the last consumed word and flags results that are not previous+1.
module gray_step_check
    import gray_pkg::*;
#(
    parameter int WIDTH = GRAY_W,
    parameter int ERR_W = GRAY_ERR_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] check_bin,
    input  logic             consume,
    input  logic [WIDTH-1:0] consumed_bin,
    input  logic             consumed_err,
    output logic             step_err,
    output logic [ERR_W-1:0] err_count
);
    logic [WIDTH-1:0] prev;
    logic             have_prev;
    logic [WIDTH-1:0] expected;

    always_comb begin
        expected = prev + 1'b1;
        step_err = have_prev & (check_bin != expected);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev      <= '0;
            have_prev <= 1'b0;
            err_count <= '0;
        end else if (consume) begin
            prev      <= consumed_bin;
            have_prev <= 1'b1;
            if (consumed_err && (err_count != '1))
                err_count <= err_count + 1'b1;
        end
    end
endmodule

// File: rtl/gray_to_bin_serial.sv
// MSB-first serial Gray-to-binary decoder with valid/ready in and out.
module gray_to_bin_serial
    import gray_pkg::*;
#(
    parameter int WIDTH = GRAY_W,
    parameter int ERR_W = GRAY_ERR_W
) (
    input logic clk,
    input logic rst,
    gray_to_bin_serial_if.slave bus
);
    localparam int IDX_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    state_t           state;
    logic [WIDTH-1:0] g_reg;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] b_next;
    logic [WIDTH-1:0] final_bin;
    logic [IDX_W-1:0] idx;
    logic             valid_q;
    logic             err_q;
    logic             step_err;
    logic             consume;

    assign bus.in_ready     = (state == IDLE) & ~rst;
    assign bus.out_valid    = valid_q;
    assign bus.out_bin      = b;
    assign bus.out_step_err = err_q;
    assign consume          = valid_q & bus.out_ready;

    // Bit idx of the result; the step check sees the completed word on the last DECODE cycle.
    always_comb begin
        b_next            = b;
        b_next[WIDTH-1]   = g_reg[WIDTH-1];
        for (int unsigned i = 0; i + 1 < WIDTH; i++) begin
            if (i == 32'(idx))
                b_next[i] = b[i+1] ^ g_reg[i];
        end
        final_bin = (WIDTH == 1) ? bus.in_gray : b_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            g_reg   <= '0;
            b       <= '0;
            idx     <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        g_reg           <= bus.in_gray;
                        b               <= '0;
                        b[WIDTH-1]      <= bus.in_gray[WIDTH-1];
                        if (WIDTH == 1) begin
                            state   <= HOLD;
                            valid_q <= 1'b1;
                            err_q   <= step_err;
                        end else begin
                            idx   <= IDX_W'(WIDTH - 2);
                            state <= DECODE;
                        end
                    end
                end
                DECODE: begin
                    b   <= b_next;
                    idx <= idx - 1'b1;
                    if (idx == '0) begin
                        state   <= HOLD;
                        valid_q <= 1'b1;
                        err_q   <= step_err;
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        valid_q <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    gray_step_check #(
        .WIDTH(WIDTH),
        .ERR_W(ERR_W)
    ) u_step_check (
        .clk         (clk),
        .rst         (rst),
        .check_bin   (final_bin),
        .consume     (consume),
        .consumed_bin(b),
        .consumed_err(err_q),
        .step_err    (step_err),
        .err_count   (bus.err_count)
    );
endmodule

// File: tb/tb_gray_to_bin_serial.sv
// Directed and randomized checks of gray_to_bin_serial against a behavioural model.
module tb_gray_to_bin_serial;
    localparam int W  = 4;
    localparam int EW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    gray_to_bin_serial_if #(.WIDTH(W), .ERR_W(EW)) bus ();

    gray_to_bin_serial #(.WIDTH(W), .ERR_W(EW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int passed = 0;
    int total  = 0;

    // Behavioural model state
    int m_prev      = 0;
    int m_have_prev = 0;
    int m_errs      = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int g2b(input int g);
        int v = g;
        int r = 0;
        while (v != 0) begin
            r ^= v;
            v = v >> 1;
        end
        return r % (1 << W);
    endfunction

    task automatic model_reset();
        m_prev      = 0;
        m_have_prev = 0;
        m_errs      = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // One full transaction: accept, wait for result, optionally stall, consume.
    task automatic do_word(input int g, input int hold, input bit full, output int acc_cyc);
        int n;
        int lat;
        int exp_bin;
        int exp_err;
        logic [W+2:0] snap;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (full) chk("accept_wait", {31'd0, bus.in_ready}, 1);
        bus.in_valid = 1'b1;
        bus.in_gray  = W'(g);
        @(negedge clk);
        acc_cyc      = cyc;
        bus.in_valid = 1'b0;
        bus.in_gray  = W'($urandom);
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            @(negedge clk);
            bus.in_gray = W'($urandom);
            lat++;
        end
        exp_bin = g2b(g);
        exp_err = (m_have_prev != 0 && exp_bin != ((m_prev + 1) % (1 << W))) ? 1 : 0;
        if (full) begin
            chk("latency", lat, W - 1);
            chk("in_ready_busy", {31'd0, bus.in_ready}, 0);
        end
        chk("out_bin", {28'd0, bus.out_bin}, exp_bin);
        chk("out_step_err", {31'd0, bus.out_step_err}, exp_err);
        snap = {bus.out_valid, bus.in_ready, bus.out_step_err, bus.out_bin};
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            bus.in_gray = W'($urandom);
            chk("hold_stable", {25'd0, bus.out_valid, bus.in_ready, bus.out_step_err, bus.out_bin},
                {25'd0, snap});
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        m_prev      = exp_bin;
        m_have_prev = 1;
        if (exp_err != 0 && m_errs < (1 << EW) - 1) m_errs++;
        if (full) begin
            chk("out_valid_drop", {31'd0, bus.out_valid}, 0);
            chk("in_ready_after", {31'd0, bus.in_ready}, 1);
        end
        chk("err_count", {24'd0, bus.err_count}, m_errs);
    endtask

    initial begin
        int acc;
        int last_acc;
        int gv;
        bit seen;
        bus.in_valid  = 1'b0;
        bus.in_gray   = '0;
        bus.out_ready = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 0);
        chk("rst_outputs", {20'd0, bus.out_valid, bus.out_step_err, bus.out_bin, 2'd0},
            0);
        chk("rst_err_count", {24'd0, bus.err_count}, 0);
        rst = 1'b0;
        #1;
        chk("in_ready_post_rst", {31'd0, bus.in_ready}, 1);
        model_reset();

        // Single decode 1101 -> 9
        do_word(4'b1101, 0, 1, acc);

        // Gray counter stream 0..15 then 0, back-to-back
        do_reset();
        last_acc = 0;
        for (int n = 0; n <= 16; n++) begin
            gv = (n % 16) ^ ((n % 16) >> 1);
            do_word(gv, 0, 1, acc);
            if (n > 0) chk("period", acc - last_acc, W + 1);
            last_acc = acc;
        end
        chk("stream_err_count", {24'd0, bus.err_count}, 0);

        // Step errors: 3, 5, 5
        do_reset();
        do_word(4'b0010, 0, 1, acc);
        do_word(4'b0111, 0, 1, acc);
        do_word(4'b0111, 0, 1, acc);
        chk("step_err_count", {24'd0, bus.err_count}, 2);

        // Backpressure with changing in_gray
        do_word(int'($urandom_range(0, 15)), 10, 1, acc);

        // Reset one cycle after accept
        bus.in_valid = 1'b1;
        bus.in_gray  = 4'b0110;
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_in_ready", {31'd0, bus.in_ready}, 0);
        chk("mid_rst_outputs", {26'd0, bus.out_valid, bus.out_step_err, bus.out_bin}, 0);
        chk("mid_rst_err_count", {24'd0, bus.err_count}, 0);
        rst = 1'b0;
        model_reset();
        #1;
        chk("mid_rst_in_ready_after", {31'd0, bus.in_ready}, 1);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        chk("no_stray_valid", {31'd0, seen}, 0);
        do_word(4'b1010, 0, 1, acc);

        // Randomized words with random stalls against the model
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0)
                gv = int'($urandom_range(0, 15));
            else
                gv = ((m_prev + 1) % 16) ^ (((m_prev + 1) % 16) >> 1);
            do_word(gv, int'($urandom_range(0, 3)), 0, acc);
        end

        // Saturation: 300 identical codes
        do_reset();
        for (int i = 0; i < 300; i++) begin
            do_word(4'b0101, 0, 0, acc);
        end
        chk("saturated", {24'd0, bus.err_count}, 255);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
